// File: rtl/adder_pkg.sv
// Shared types and parameter checks for the digit-serial adder.
// The adder works one DIGIT-bit slice per clock.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit params_legal(input int width, input int digit);
        return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple-carry adder for one DIGIT-bit slice.
// Also exports the carry into the top bit, which is needed for the signed-overflow flag.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_ci,
    output logic [DIGIT-1:0] o_s,
    output logic             o_co,
    output logic             o_c_msb
);

    logic [DIGIT:0] w_c;

    always_comb begin
        w_c    = '0;
        o_s    = '0;
        w_c[0] = i_ci;
        for (int i = 0; i < DIGIT; i++) begin
            o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_co    = w_c[DIGIT];
    assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract of two WIDTH-bit operands, LSB digit first,
// with valid/ready handshakes and carry / signed-overflow flags.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG) + 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (!params_legal(WIDTH, DIGIT)) begin : g_bad_params
        $error("digit_serial_adder: DIGIT must divide WIDTH");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT-1:0]       w_s;
    logic                   w_co;
    logic                   w_c_msb;
    logic [WIDTH+DIGIT-1:0] w_sum_ext;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .i_a     (r_a[DIGIT-1:0]),
        .i_b     (r_b[DIGIT-1:0]),
        .i_ci    (r_carry),
        .o_s     (w_s),
        .o_co    (w_co),
        .o_c_msb (w_c_msb)
    );

    // New digit enters at the MSB end; after NDIG shifts digit 0 lands at bit 0.
    assign w_sum_ext = {w_s, r_sum};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_sum   <= w_sum_ext[WIDTH+DIGIT-1:DIGIT];
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_co;
                    if (r_cnt == LAST) begin
                        r_cout      <= w_co;
                        r_ovf       <= w_co ^ w_c_msb;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
